fft_frame_scheduler: RTL and testbench

Frame-level controller wrapped around FFT_IMPLEMENTATION. It gates the 12-bit ADC sample stream into the FFT one frame (FFT_LENGTH samples) at a time and holds the FFT in reset between frames. After done_FFT it steps the output index and scans the magnitude stream for the peak bin. It then presents a per-frame {peak_bin, peak_mag} result to the fingerprint logic over a valid/ready handshake.

---
 rtl/fft_frame_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// -----------------------------------------------------------------------------
// fft_frame_scheduler
//
// Frame-level controller that sits around a streaming FFT core.
//  - Gates the 12-bit ADC sample stream into the FFT, one frame of FFT_LENGTH
//    samples at a time. Between frames the FFT is held in reset.
//  - After the FFT reports done, it steps the FFT readout index.
//  - It scans the magnitude stream over bins 1..FFT_LENGTH/2-1 for the peak.
//  - It presents {peak_bin, peak_mag} to the consumer over valid/ready.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous active-low reset
//   enable_i          run request (level)
//   adc_data_i/valid  ADC sample and its one-cycle strobe
//   fft_reset_o       1 = FFT held in reset
//   fft_in_valid_o    sample forward strobe (1 cycle after adc strobe)
//   fft_in_real_o     {adc_data, 4'b0000}
//   fft_done_i        FFT computation complete
//   fft_index_o       FFT readout index, steps on fft_out_ready_i
//   fft_out_ready_i   FFT readout ready pulse
//   magnitude_i/_ready_i  magnitude stream from the FFT
//   peak_bin_o/peak_mag_o result of the last completed frame
//   result_valid_o/result_ready_i  result handshake
//   frame_count_o     accepted frames (wraps)
//   overrun_o         sticky: sample arrived outside FILL
//   timeout_o         sticky: FFT never reported done
// -----------------------------------------------------------------------------
module fft_frame_scheduler #(
    parameter int FFT_LENGTH = 1024,
    parameter int IDX_W      = $clog2(FFT_LENGTH),
    parameter int TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [11:0]      adc_data_i,
    input  logic             adc_valid_i,
    output logic             fft_reset_o,
    output logic             fft_in_valid_o,
    output logic [15:0]      fft_in_real_o,
    input  logic             fft_done_i,
    output logic [IDX_W-1:0] fft_index_o,
    input  logic             fft_out_ready_i,
    input  logic [15:0]      magnitude_i,
    input  logic             magnitude_ready_i,
    output logic [IDX_W-1:0] peak_bin_o,
    output logic [15:0]      peak_mag_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [15:0]      frame_count_o,
    output logic             overrun_o,
    output logic             timeout_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_SAMPLE = IDX_W'(FFT_LENGTH - 1);
    localparam logic [IDX_W-1:0] LAST_MAG    = IDX_W'(FFT_LENGTH / 2 - 1);
    localparam logic [TW-1:0]    TO_LAST     = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_COMPUTE,
        S_READOUT,
        S_REPORT
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   sample_cnt_reg;
    logic [IDX_W-1:0]   mag_cnt_reg;
    logic [TW-1:0]      tmo_cnt_reg;
    logic               fft_reset_reg;
    logic               fft_in_valid_reg;
    logic [15:0]        fft_in_real_reg;
    logic [IDX_W-1:0]   fft_index_reg;
    logic [IDX_W-1:0]   peak_bin_reg;
    logic [15:0]        peak_mag_reg;
    logic               result_valid_reg;
    logic [15:0]        frame_count_reg;
    logic               overrun_reg;
    logic               timeout_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            sample_cnt_reg   <= '0;
            mag_cnt_reg      <= '0;
            tmo_cnt_reg      <= '0;
            fft_reset_reg    <= 1'b1;
            fft_in_valid_reg <= 1'b0;
            fft_in_real_reg  <= '0;
            fft_index_reg    <= '0;
            peak_bin_reg     <= '0;
            peak_mag_reg     <= '0;
            result_valid_reg <= 1'b0;
            frame_count_reg  <= '0;
            overrun_reg      <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            // Forward strobe is a single-cycle pulse unless FILL re-arms it.
            fft_in_valid_reg <= 1'b0;

            // Any sample outside FILL is dropped and flagged.
            if (adc_valid_i && (state_reg != S_FILL))
                overrun_reg <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    sample_cnt_reg <= '0;
                    mag_cnt_reg    <= '0;
                    fft_index_reg  <= '0;
                    peak_bin_reg   <= '0;
                    peak_mag_reg   <= '0;
                    fft_reset_reg  <= 1'b1;
                    if (enable_i) begin
                        state_reg     <= S_FILL;
                        fft_reset_reg <= 1'b0;
                    end
                end

                S_FILL: begin
                    if (!enable_i) begin
                        // Abort: partial frame is discarded, FFT re-held.
                        state_reg     <= S_IDLE;
                        fft_reset_reg <= 1'b1;
                    end else if (adc_valid_i) begin
                        fft_in_valid_reg <= 1'b1;
                        fft_in_real_reg  <= {adc_data_i, 4'b0000};
                        sample_cnt_reg   <= sample_cnt_reg + 1'b1;
                        if (sample_cnt_reg == LAST_SAMPLE) begin
                            state_reg   <= S_COMPUTE;
                            tmo_cnt_reg <= '0;
                        end
                    end
                end

                S_COMPUTE: begin
                    if (fft_done_i) begin
                        state_reg <= S_READOUT;
                    end else if (tmo_cnt_reg == TO_LAST) begin
                        timeout_reg   <= 1'b1;
                        state_reg     <= S_IDLE;
                        fft_reset_reg <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                S_READOUT: begin
                    // Index is a power-of-two width, so it wraps naturally.
                    if (fft_out_ready_i)
                        fft_index_reg <= fft_index_reg + 1'b1;
                    if (magnitude_ready_i) begin
                        // DC bin skipped; strict compare keeps the lowest bin on ties.
                        // Mirror bins never arrive here: we leave at bin N/2-1.
                        if ((mag_cnt_reg != '0) && (magnitude_i > peak_mag_reg)) begin
                            peak_bin_reg <= mag_cnt_reg;
                            peak_mag_reg <= magnitude_i;
                        end
                        mag_cnt_reg <= mag_cnt_reg + 1'b1;
                        if (mag_cnt_reg == LAST_MAG) begin
                            state_reg        <= S_REPORT;
                            fft_reset_reg    <= 1'b1;
                            result_valid_reg <= 1'b1;
                        end
                    end
                end

                S_REPORT: begin
                    if (result_ready_i) begin
                        frame_count_reg  <= frame_count_reg + 1'b1;
                        result_valid_reg <= 1'b0;
                        // Start the next frame from a clean slate.
                        sample_cnt_reg   <= '0;
                        mag_cnt_reg      <= '0;
                        fft_index_reg    <= '0;
                        peak_bin_reg     <= '0;
                        peak_mag_reg     <= '0;
                        if (enable_i) begin
                            state_reg     <= S_FILL;
                            fft_reset_reg <= 1'b0;
                        end else begin
                            state_reg     <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_reg     <= S_IDLE;
                    fft_reset_reg <= 1'b1;
                end
            endcase
        end
    end

    assign fft_reset_o    = fft_reset_reg;
    assign fft_in_valid_o = fft_in_valid_reg;
    assign fft_in_real_o  = fft_in_real_reg;
    assign fft_index_o    = fft_index_reg;
    assign peak_bin_o     = peak_bin_reg;
    assign peak_mag_o     = peak_mag_reg;
    assign result_valid_o = result_valid_reg;
    assign frame_count_o  = frame_count_reg;
    assign overrun_o      = overrun_reg;
    assign timeout_o      = timeout_reg;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for fft_frame_scheduler (FFT_LENGTH=16, TIMEOUT=100).
// Stimulus pushes expected forwarded samples and expected frame results into
// queues; a negedge monitor pops and compares them when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_fft_frame_scheduler;

    localparam int N     = 16;
    localparam int IW    = 4;
    localparam int TMO   = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [11:0]   adc_data;
    logic          adc_valid;
    logic          fft_reset;
    logic          fft_in_valid;
    logic [15:0]   fft_in_real;
    logic          fft_done;
    logic [IW-1:0] fft_index;
    logic          fft_out_ready;
    logic [15:0]   magnitude;
    logic          magnitude_ready;
    logic [IW-1:0] peak_bin;
    logic [15:0]   peak_mag;
    logic          result_valid;
    logic          result_ready;
    logic [15:0]   frame_count;
    logic          overrun;
    logic          timeout;

    fft_frame_scheduler #(
        .FFT_LENGTH (N),
        .IDX_W      (IW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk               (clk),
        .reset             (rst_n),
        .enable_i          (enable),
        .adc_data_i        (adc_data),
        .adc_valid_i       (adc_valid),
        .fft_reset_o       (fft_reset),
        .fft_in_valid_o    (fft_in_valid),
        .fft_in_real_o     (fft_in_real),
        .fft_done_i        (fft_done),
        .fft_index_o       (fft_index),
        .fft_out_ready_i   (fft_out_ready),
        .magnitude_i       (magnitude),
        .magnitude_ready_i (magnitude_ready),
        .peak_bin_o        (peak_bin),
        .peak_mag_o        (peak_mag),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .frame_count_o     (frame_count),
        .overrun_o         (overrun),
        .timeout_o         (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboards
    int          exp_cyc_q[$];
    logic [15:0] exp_real_q[$];
    logic [19:0] exp_res_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one strobe in the current cycle (caller is just after a posedge).
    task automatic strobe_now(input logic [11:0] d);
        adc_data  = d;
        adc_valid = 1'b1;
        exp_cyc_q.push_back(cyc + 1);
        exp_real_q.push_back({d, 4'b0000});
    endtask

    // Monitor: forwarded samples and frame results.
    initial begin
        forever begin
            @(negedge clk);
            if (fft_in_valid) begin
                if (exp_real_q.size() == 0) begin
                    check("unexpected_fft_in_valid", 32'(fft_in_real), 32'hFFFF_FFFF);
                end else begin
                    check("fft_in_real", 32'(fft_in_real), 32'(exp_real_q.pop_front()));
                    check("fft_in_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                check("missed_fft_in_valid", 32'(cyc), 32'(exp_cyc_q[0]));
                void'(exp_cyc_q.pop_front());
                void'(exp_real_q.pop_front());
            end
            if (result_valid && result_ready) begin
                if (exp_res_q.size() == 0)
                    check("unexpected_result", {12'd0, peak_bin, peak_mag}, 32'hFFFF_FFFF);
                else
                    check("result_peak", {12'd0, peak_bin, peak_mag}, {12'd0, exp_res_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] mags1 [0:9];
    logic [15:0] mags2 [0:7];

    initial begin
        mags1 = '{16'd900, 16'd5, 16'd7, 16'd300, 16'd12, 16'd300, 16'd1, 16'd2, 16'd9999, 16'd9999};
        mags2 = '{16'd0, 16'd10, 16'd40, 16'd40, 16'd3, 16'd39, 16'd0, 16'd41};
        rst_n = 1'b0; enable = 1'b0; adc_data = '0; adc_valid = 1'b0;
        fft_done = 1'b0; fft_out_ready = 1'b0; magnitude = '0;
        magnitude_ready = 1'b0; result_ready = 1'b0;

        // ---------------- reset state
        repeat (3) tick();
        check("rst_fft_reset", 32'(fft_reset), 32'd1);
        check("rst_in_valid", 32'(fft_in_valid), 32'd0);
        check("rst_index", 32'(fft_index), 32'd0);
        check("rst_peak", {12'd0, peak_bin, peak_mag}, 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_flags", {frame_count, 14'd0, overrun, timeout}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- frame 1: spaced strobes, data 0..15
        enable = 1'b1;
        tick();                             // IDLE -> FILL
        check("fill_fft_reset", 32'(fft_reset), 32'd0);
        for (int i = 0; i < N; i++) begin
            strobe_now(12'(i));
            tick();
            adc_valid = 1'b0;
            repeat (19) tick();
            if (i == 7) check("fill_mid_fft_reset", 32'(fft_reset), 32'd0);
        end
        check("compute_fft_reset", 32'(fft_reset), 32'd0);
        check("compute_no_result", 32'(result_valid), 32'd0);

        fft_done = 1'b1;
        tick();                             // COMPUTE -> READOUT
        fft_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("readout_index", 32'(fft_index), 32'(i));
            fft_out_ready = 1'b1;
            tick();
            fft_out_ready = 1'b0;
        end
        check("readout_index_wrap", 32'(fft_index), 32'd0);

        exp_res_q.push_back({4'd3, 16'd300});
        for (int i = 0; i < 10; i++) begin
            magnitude = mags1[i];
            magnitude_ready = 1'b1;
            tick();
        end
        magnitude_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (10) tick();
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_peak_bin", 32'(peak_bin), 32'd3);
            check("hold_peak_mag", 32'(peak_mag), 32'd300);
        end
        result_ready = 1'b1;
        tick();                             // handshake
        result_ready = 1'b0;
        check("f1_frame_count", 32'(frame_count), 32'd1);
        check("f1_valid_drop", 32'(result_valid), 32'd0);
        check("f1_back_to_fill", 32'(fft_reset), 32'd0);

        // ---------------- abort after 5 samples
        for (int i = 0; i < 5; i++) begin
            strobe_now(12'(12'h800 + i));
            tick();
            adc_valid = 1'b0;
            tick();
        end
        enable = 1'b0;
        tick();
        check("abort_fft_reset", 32'(fft_reset), 32'd1);
        tick();
        check("abort_no_result", 32'(result_valid), 32'd0);

        // ---------------- frame 2: full frame after re-enable
        enable = 1'b1;
        tick();                             // IDLE -> FILL
        for (int i = 0; i < N; i++) begin
            strobe_now(12'(100 + 7 * i));
            tick();
            adc_valid = 1'b0;
            repeat (2) tick();
            if (i == 10) check("f2_still_fill", 32'(fft_reset), 32'd0);
        end
        check("f2_no_overrun", 32'(overrun), 32'd0);
        enable = 1'b0;                      // does not abort past FILL
        result_ready = 1'b1;
        repeat (3) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        exp_res_q.push_back({4'd7, 16'd41});
        for (int i = 0; i < 8; i++) begin
            magnitude = mags2[i];
            magnitude_ready = 1'b1;
            tick();
        end
        magnitude_ready = 1'b0;
        tick();                             // accepted in first REPORT cycle
        result_ready = 1'b0;
        check("f2_frame_count", 32'(frame_count), 32'd2);
        check("f2_idle_fft_reset", 32'(fft_reset), 32'd1);
        check("f2_valid_drop", 32'(result_valid), 32'd0);

        // ---------------- overrun + timeout
        enable = 1'b1;
        tick();                             // IDLE -> FILL
        for (int i = 0; i < N; i++) begin
            strobe_now(12'(12'hF00 + i));
            tick();                         // back-to-back
        end
        adc_valid = 1'b0;                   // now in COMPUTE
        enable = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (c == 10) begin
                adc_data  = 12'hABC;
                adc_valid = 1'b1;
            end
            if (c == 11) begin
                adc_valid = 1'b0;
                check("overrun_set", 32'(overrun), 32'd1);
            end
            if (c == TMO - 1) begin
                check("timeout_early", 32'(timeout), 32'd0);
                check("timeout_early_fft_reset", 32'(fft_reset), 32'd0);
            end
            if (c == TMO) begin
                check("timeout_set", 32'(timeout), 32'd1);
                check("timeout_idle", 32'(fft_reset), 32'd1);
            end
        end
        repeat (5) tick();
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("timeout_no_result", 32'(result_valid), 32'd0);
        check("timeout_frame_count", 32'(frame_count), 32'd2);

        // ---------------- reset during READOUT
        enable = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            strobe_now(12'(i * 3));
            tick();
        end
        adc_valid = 1'b0;
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fft_out_ready = 1'b1;
            tick();
        end
        fft_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            magnitude = 16'(5 + i);
            magnitude_ready = 1'b1;
            tick();
        end
        magnitude_ready = 1'b0;
        check("pre_rst_index", 32'(fft_index), 32'd2);
        check("pre_rst_peak", {12'd0, peak_bin, peak_mag}, {12'd0, 4'd2, 16'd7});
        #1 rst_n = 1'b0;                    // mid-cycle: asynchronous
        #1;
        check("arst_fft_reset", 32'(fft_reset), 32'd1);
        check("arst_index", 32'(fft_index), 32'd0);
        check("arst_peak", {12'd0, peak_bin, peak_mag}, 32'd0);
        check("arst_flags", {frame_count, 14'd0, overrun, timeout}, 32'd0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(fft_reset), 32'd1);
        check("post_rst_valid", 32'(result_valid), 32'd0);

        repeat (3) tick();
        check("sample_queue_empty", 32'(exp_real_q.size()), 32'd0);
        check("result_queue_empty", 32'(exp_res_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
